// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter onto a single-port synchronous data RAM with window range check
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000192E,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_valid,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_valid,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [31:0] LAST = BASE_ADDR + 32'(DEPTH - 1);
  state_t state;
  logic prio, gport, perr, pwe;
  logic any, win, we, hit;
  logic [31:0] addr;
  logic [DATA_W-1:0] wdata, rd;
  always_comb begin
    any = m0_req | m1_req;
    win = (m0_req && m1_req) ? prio : m1_req;
    addr = win ? m1_addr : m0_addr;
    we = win ? m1_we : m0_we;
    wdata = win ? m1_wdata : m0_wdata;
    hit = (addr >= BASE_ADDR) && (addr <= LAST);
    rd = (perr || pwe) ? '0 : mem_rdata;
  end
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      gport <= 1'b0;
      perr <= 1'b0;
      pwe <= 1'b0;
      m0_gnt <= 1'b0;
      m0_valid <= 1'b0;
      m0_err <= 1'b0;
      m0_rdata <= '0;
      m1_gnt <= 1'b0;
      m1_valid <= 1'b0;
      m1_err <= 1'b0;
      m1_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_valid <= 1'b0;
      m1_valid <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (state == RESP) begin
        m0_valid <= !gport;
        m1_valid <= gport;
        m0_err <= !gport && perr;
        m1_err <= gport && perr;
        m0_rdata <= gport ? '0 : rd;
        m1_rdata <= gport ? rd : '0;
      end
      if (state == ISSUE) state <= RESP;
      else if (any) begin
        state <= ISSUE;
        m0_gnt <= !win;
        m1_gnt <= win;
        prio <= !win;
        gport <= win;
        perr <= !hit;
        pwe <= we;
        mem_en <= hit;
        mem_we <= hit && we;
        mem_addr <= ADDR_W'(addr - BASE_ADDR);
        mem_wdata <= wdata;
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural synchronous RAM
module tb_dmem_arbiter;
  logic CLK = 0, rst = 0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic m0_gnt, m0_valid, m0_err, m1_gnt, m1_valid, m1_err;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [31:0] ram [0:1023];
  int tests = 0, fails = 0;

  dmem_arbiter dut (
    .CLK(CLK), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_valid(m0_valid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_valid(m1_valid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic start(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    #2 rst = 1; #1;
    tests++;
    if ({m0_gnt, m0_valid, m0_err, m0_rdata, m1_gnt, m1_valid, m1_err, m1_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (mem_en !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        fails++; $display("FAIL reset_idle[%0d]: mem_en=%b gnt=%b%b, required 0", i, mem_en, m0_gnt, m1_gnt);
      end
    end
  endtask

  task automatic test_single_read();
    ram[15] = 32'hDEADBEEF;
    start(0, 0, 32'h193D, 0);
    tick();
    drop();
    tests++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 10'h00F) begin
      fails++; $display("FAIL read_issue: gnt=%b%b en=%b we=%b addr=%h, required gnt0 en=1 we=0 addr=00f", m0_gnt, m1_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    tests++;
    if (mem_en !== 0 || m0_gnt !== 0 || m0_valid !== 0) begin
      fails++; $display("FAIL read_wait: en=%b gnt=%b valid=%b, required 0", mem_en, m0_gnt, m0_valid);
    end
    tick();
    tests++;
    if (m0_valid !== 1 || m0_rdata !== 32'hDEADBEEF || m0_err !== 0 || m1_valid !== 0) begin
      fails++; $display("FAIL read_resp: valid=%b rdata=%h err=%b, required 1 deadbeef 0", m0_valid, m0_rdata, m0_err);
    end
    tick();
    tests++;
    if (m0_valid !== 0 || m0_rdata !== 0) begin
      fails++; $display("FAIL read_pulse: valid=%b rdata=%h, required 0 0", m0_valid, m0_rdata);
    end
  endtask

  task automatic test_boundary_writes();
    logic [31:0] a [2];
    logic [9:0] ix [2];
    logic [31:0] d [2];
    a[0] = 32'h192E; a[1] = 32'h1D2D;
    ix[0] = 10'h000; ix[1] = 10'h3FF;
    d[0] = 32'hA5A50001; d[1] = 32'h5A5A03FF;
    for (int i = 0; i < 2; i++) begin
      start(1, 1, a[i], d[i]);
      tick();
      drop();
      tests++;
      if (m1_gnt !== 1 || mem_en !== 1 || mem_we !== 1 || mem_addr !== ix[i] || mem_wdata !== d[i]) begin
        fails++; $display("FAIL bwrite_issue[%0d]: gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 %h %h", i, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, ix[i], d[i]);
      end
      tick(); tick();
      tests++;
      if (m1_valid !== 1 || m1_err !== 0 || m1_rdata !== 0 || m0_valid !== 0) begin
        fails++; $display("FAIL bwrite_resp[%0d]: valid=%b err=%b rdata=%h, required 1 0 0", i, m1_valid, m1_err, m1_rdata);
      end
      tests++;
      if (ram[ix[i]] !== d[i]) begin
        fails++; $display("FAIL bwrite_ram[%0d]: ram=%h, required %h", i, ram[ix[i]], d[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] a [2];
    a[0] = 32'h1920; a[1] = 32'h1D2E;
    for (int i = 0; i < 2; i++) begin
      start(0, 1, a[i], 32'hFFFF0000);
      tick();
      drop();
      tests++;
      if (m0_gnt !== 1 || mem_en !== 0 || mem_we !== 0) begin
        fails++; $display("FAIL oor_issue[%0d]: gnt=%b en=%b we=%b, required 1 0 0", i, m0_gnt, mem_en, mem_we);
      end
      tick(); tick();
      tests++;
      if (m0_valid !== 1 || m0_err !== 1 || m0_rdata !== 0) begin
        fails++; $display("FAIL oor_resp[%0d]: valid=%b err=%b rdata=%h, required 1 1 0", i, m0_valid, m0_err, m0_rdata);
      end
    end
  endtask

  task automatic test_contention();
    #2 rst = 1; #2 rst = 0;
    start(0, 0, 32'h192E, 0);
    start(1, 0, 32'h1930, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      tests++;
      if (m0_gnt !== (i % 4 == 0) || m1_gnt !== (i % 4 == 2) || m0_valid !== (i % 4 == 2) || m1_valid !== (i % 4 == 0 && i > 0)) begin
        fails++; $display("FAIL contention[%0d]: gnt=%b%b valid=%b%b, required gnt=%b%b valid=%b%b", i, m0_gnt, m1_gnt, m0_valid, m1_valid, i % 4 == 0, i % 4 == 2, i % 4 == 2, i % 4 == 0 && i > 0);
      end
    end
    drop();
    tick(); tick(); tick();
  endtask

  task automatic test_abort();
    ram[10'h0EF] = 32'h0BADF00D;
    start(1, 1, 32'h1A1D, 32'h11223344);
    tick();
    drop();
    tests++;
    if (m1_gnt !== 1 || mem_en !== 1 || mem_we !== 1 || mem_addr !== 10'h0EF) begin
      fails++; $display("FAIL abort_issue: gnt=%b en=%b we=%b addr=%h, required 1 1 1 0ef", m1_gnt, mem_en, mem_we, mem_addr);
    end
    #2 rst = 1; #1;
    tests++;
    if (mem_en !== 0 || mem_we !== 0 || m1_gnt !== 0) begin
      fails++; $display("FAIL abort_clear: en=%b we=%b gnt=%b, required 0", mem_en, mem_we, m1_gnt);
    end
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (m1_valid !== 0 || m0_valid !== 0) begin
        fails++; $display("FAIL abort_novalid[%0d]: valid=%b%b, required 00", i, m0_valid, m1_valid);
      end
    end
    tests++;
    if (ram[10'h0EF] !== 32'h0BADF00D) begin
      fails++; $display("FAIL abort_ram: ram=%h, required 0badf00d", ram[10'h0EF]);
    end
    start(1, 0, 32'h1A1D, 0);
    tick();
    drop();
    tests++;
    if (m1_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 10'h0EF) begin
      fails++; $display("FAIL abort_reread_issue: gnt=%b en=%b we=%b addr=%h, required 1 1 0 0ef", m1_gnt, mem_en, mem_we, mem_addr);
    end
    tick(); tick();
    tests++;
    if (m1_valid !== 1 || m1_err !== 0 || m1_rdata !== 32'h0BADF00D) begin
      fails++; $display("FAIL abort_reread_resp: valid=%b err=%b rdata=%h, required 1 0 0badf00d", m1_valid, m1_err, m1_rdata);
    end
  endtask

  initial begin
    mem_rdata = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    test_reset();
    test_single_read();
    test_boundary_writes();
    test_out_of_range();
    test_contention();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between two bus masters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader). Each request is range-checked against the data-memory window, translated to a word index and issued to the synchronous RAM. The read data or an error is then returned to the requester with a one-cycle valid pulse. The block sits between the masters and the RAM and takes over the chip-select, write-gating and address-translation role for that window.

## Interface
- BASE_ADDR, 32'h0000192E, first byte-address of the data-memory window
- DEPTH, 1024, number of words in the window
- ADDR_W, 10, RAM index width (log2 DEPTH)
- DATA_W, 32, data width
- CLK  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mN_req  in  1  port N request (N = 0,1); held with mN_we/addr/wdata stable until mN_gnt sampled high
- mN_we  in  1  port N write enable
- mN_addr  in  32  port N address
- mN_wdata  in  DATA_W  port N write data
- mN_gnt  out  1  port N request accepted (1-cycle pulse)
- mN_valid  out  1  port N response strobe (1-cycle pulse)
- mN_err  out  1  port N address out of window; qualified by mN_valid
- mN_rdata  out  DATA_W  port N read data; qualified by mN_valid
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word index
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en (synchronous RAM)

## Operation
- All outputs are registered. On rst, every output is 0, state = IDLE, prio = 0 (port 0 favoured).
- States: IDLE, ISSUE, RESP.
- IDLE: if any req is high, pick a winner, register the memory signals, pulse the winner's gnt and go to ISSUE. Otherwise stay in IDLE.
- Winner selection: if only one port requests, it wins. If both request, the port equal to prio wins. After each grant, prio is set to the other port.
- Range check: in_range = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+DEPTH-1), as a 32-bit unsigned compare. The index is mem_addr = (addr - BASE_ADDR)[ADDR_W-1:0].
- In range: mem_en = 1, mem_we = winner we, mem_addr = translated index, mem_wdata = winner wdata.
- Out of range: mem_en = 0 and mem_we = 0; a pending error is recorded.
- ISSUE: mem_en, mem_we and gnt return to 0; requests are ignored; go to RESP.
- RESP: pulse the granted port's valid.
  - In-range read: rdata = mem_rdata, err = 0.
  - Write: rdata = 0, err = 0.
  - Out-of-range access: rdata = 0, err = 1.
  - In the same edge, arbitrate as in IDLE. If any req is high, go to ISSUE with a new grant; otherwise go to IDLE.
- The ungranted port's outputs stay 0 throughout.
- Reset mid-transaction aborts the transaction: no valid is issued and the RAM is not written after the rst edge.

## Timing
- Request sampled high at edge k in IDLE:
  - mem_en and gnt are high between edges k and k+1; the RAM acts at edge k+1.
  - valid is high between edges k+2 and k+3.
  - Latency from request to response is 2 cycles.
- Back-to-back requests: RESP-to-ISSUE chaining gives sustained throughput of one access per 2 cycles. The next gnt coincides with the current valid.
- A master may drop its req, or present a new request, from the edge at which it samples gnt = 1.
- Requests arriving while in ISSUE are not lost: they are held by the master and arbitrated at the next RESP/IDLE edge.
- gnt and valid are never high on both ports in the same cycle.
- mem_en is never high for two consecutive cycles.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs go to 0 immediately; after release, with no requests, mem_en stays 0.
- Single read: m0 reads 0x193D -> mem_addr = 0x00F, mem_we = 0 one cycle after the request. Two cycles after the request, m0_valid = 1, m0_rdata = the value the RAM returned, m0_err = 0.
- Boundary writes: m1 writes 0x192E, then 0x1D2D, with WE = 1:
  - mem_addr = 0x000, then 0x3FF;
  - mem_we = 1 each time;
  - m1_valid pulses with m1_err = 0.
- Out of range: m0 accesses 0x1920, then 0x1D2E, with WE = 1 -> mem_en stays 0, m0_valid = 1 with m0_err = 1 and m0_rdata = 0.
- Contention: both ports request continuously from reset -> grants alternate m0, m1, m0, m1 at one grant per 2 cycles; no cycle has both gnt or both valid high.
- Abort: assert rst during ISSUE of an m1 write to 0x1A1D -> no m1_valid; after reset, a read of 0x1A1D presents mem_addr = 0x0EF.
